// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues busywait fetches, loads IF/ID,
// buffers one completed fetch while decode stalls, and handles EX redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        IMEM_BUSY,
    input  logic [31:0] IMEM_READDATA,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_INSTRUCTION,
    output logic        IF_ID_VALID
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] saved_tgt_q, saved_tgt_d;

    logic            accept;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] tgt_aligned;

    assign accept      = (state_q == FETCH) && !IMEM_BUSY;
    assign pc_plus4    = pc_q + INSTR_BYTES;
    assign tgt_aligned = BRANCH_TARGET & ALIGN_MASK;

    // Request is gated by RESET so it drops the moment reset asserts.
    assign IMEM_READ         = RESET && (state_q == FETCH);
    assign IMEM_ADDRESS      = pc_q;
    assign PC                = pc_q;
    assign IF_ID_PC          = ifid_q.pc;
    assign IF_ID_PC4         = ifid_q.pc4;
    assign IF_ID_INSTRUCTION = ifid_q.instr;
    assign IF_ID_VALID       = ifid_q.valid;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ifid_q      <= '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            discard_q   <= 1'b0;
            saved_tgt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ifid_q      <= ifid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            discard_q   <= discard_d;
            saved_tgt_q <= saved_tgt_d;
        end
    end

    // Next-state: redirect beats stall and accept; a busy request is finished then dropped.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_d      = ifid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        discard_d   = discard_q;
        saved_tgt_d = saved_tgt_q;

        if (BRANCH_TAKEN) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
            state_d      = FETCH;
            if ((state_q == HOLD) || !IMEM_BUSY) begin
                pc_d      = tgt_aligned;
                discard_d = 1'b0;
            end else begin
                saved_tgt_d = tgt_aligned;
                discard_d   = 1'b1;
            end
        end else if (state_q == FETCH) begin
            if (accept) begin
                if (discard_q) begin
                    pc_d      = saved_tgt_q;
                    discard_d = 1'b0;
                end else if (!STALL) begin
                    ifid_d = '{pc: pc_q, pc4: pc_plus4, instr: IMEM_READDATA, valid: 1'b1};
                    pc_d   = pc_plus4;
                end else begin
                    buf_pc_d    = pc_q;
                    buf_instr_d = IMEM_READDATA;
                    pc_d        = pc_plus4;
                    state_d     = HOLD;
                end
            end
        end else if (!STALL) begin
            ifid_d  = '{pc: buf_pc_q, pc4: buf_pc_q + INSTR_BYTES, instr: buf_instr_q, valid: 1'b1};
            state_d = FETCH;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued when a fetch
// is driven and popped when the stage is due to load IF/ID.
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_BUSY;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] PC;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_INSTRUCTION;
    logic        IF_ID_VALID;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    if_stage dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .STALL            (STALL),
        .BRANCH_TAKEN     (BRANCH_TAKEN),
        .BRANCH_TARGET    (BRANCH_TARGET),
        .IMEM_BUSY        (IMEM_BUSY),
        .IMEM_READDATA    (IMEM_READDATA),
        .IMEM_READ        (IMEM_READ),
        .IMEM_ADDRESS     (IMEM_ADDRESS),
        .PC               (PC),
        .IF_ID_PC         (IF_ID_PC),
        .IF_ID_PC4        (IF_ID_PC4),
        .IF_ID_INSTRUCTION(IF_ID_INSTRUCTION),
        .IF_ID_VALID      (IF_ID_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_t e;
        e.pc = a; e.instr = word(a); e.valid = 1'b1;
        sb.push_back(e);
    endtask

    task automatic push_flush();
        exp_t e;
        e.pc = '0; e.instr = NOP; e.valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_instr"}, IF_ID_INSTRUCTION, e.instr);
        chk({tag, "_valid"}, 32'(IF_ID_VALID), 32'(e.valid));
        if (e.valid) begin
            chk({tag, "_pc"},  IF_ID_PC,  e.pc);
            chk({tag, "_pc4"}, IF_ID_PC4, e.pc + 32'd4);
        end
    endtask

    // One zero-wait fetch at address a, no stall, no redirect.
    task automatic fetch(input string tag, input logic [31:0] a);
        STALL = 1'b0; BRANCH_TAKEN = 1'b0; IMEM_BUSY = 1'b0; IMEM_READDATA = word(a);
        #1;
        chk({tag, "_addr"}, IMEM_ADDRESS, a);
        chk({tag, "_read"}, 32'(IMEM_READ), 32'd1);
        push_fetch(a);
        tick();
        pop_cmp(tag);
    endtask

    // Zero-wait redirect; IF/ID flushed and PC lands on the aligned target.
    task automatic redirect(input string tag, input logic [31:0] tgt);
        STALL = 1'b0; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = tgt; IMEM_BUSY = 1'b0;
        IMEM_READDATA = 32'hDEAD_BEEF;
        push_flush();
        tick();
        BRANCH_TAKEN = 1'b0;
        pop_cmp(tag);
        chk({tag, "_pc"}, PC, tgt & ~32'd3);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        #1;
    endtask

    initial begin
        RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
        IMEM_BUSY = 1'b0; IMEM_READDATA = '0;
        tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_read", 32'(IMEM_READ), 32'd0);
        chk("rst_ifid_pc", IF_ID_PC, 32'h0);
        chk("rst_ifid_pc4", IF_ID_PC4, 32'h0);
        chk("rst_instr", IF_ID_INSTRUCTION, NOP);
        chk("rst_valid", 32'(IF_ID_VALID), 32'd0);
        tick();
        RESET = 1'b1;
        #1;
        chk("first_req", 32'(IMEM_READ), 32'd1);

        // 1: back-to-back zero-wait fetches
        for (int k = 0; k < 4; k++) fetch($sformatf("t1_f%0d", k), 32'(k * 4));

        // 2: busy on address 8 for three cycles
        do_reset();
        fetch("t2_f0", 32'h0);
        fetch("t2_f4", 32'h4);
        IMEM_BUSY = 1'b1; IMEM_READDATA = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t2_busy_addr%0d", k), IMEM_ADDRESS, 32'h8);
            tick();
            chk($sformatf("t2_busy_ifid%0d", k), IF_ID_PC, 32'h4);
        end
        fetch("t2_f8", 32'h8);
        chk("t2_next_addr", IMEM_ADDRESS, 32'hC);

        // 3: stall while fetch of 4 completes, then release
        do_reset();
        fetch("t3_f0", 32'h0);
        STALL = 1'b1; IMEM_BUSY = 1'b0; IMEM_READDATA = word(32'h4);
        push_fetch(32'h4);
        tick();
        IMEM_READDATA = 32'hBAD1_BAD1;
        chk("t3_hold_read", 32'(IMEM_READ), 32'd0);
        chk("t3_hold_ifid", IF_ID_PC, 32'h0);
        tick();
        chk("t3_hold2_read", 32'(IMEM_READ), 32'd0);
        chk("t3_hold2_ifid", IF_ID_PC, 32'h0);
        STALL = 1'b0;
        tick();
        pop_cmp("t3_release");
        chk("t3_resume_read", 32'(IMEM_READ), 32'd1);
        chk("t3_resume_addr", IMEM_ADDRESS, 32'h8);

        // 4: zero-wait redirect to unaligned target
        redirect("t4_br", 32'h0000_0103);
        chk("t4_addr", IMEM_ADDRESS, 32'h100);
        fetch("t4_f100", 32'h100);

        // redirect while in HOLD
        STALL = 1'b1; IMEM_READDATA = word(32'h104);
        tick();
        chk("hold_br_read", 32'(IMEM_READ), 32'd0);
        redirect("hold_br", 32'h0000_0080);
        fetch("hold_br_f80", 32'h80);

        // 5: two redirects while busy on 0x10; newest target wins
        redirect("t5_to10", 32'h10);
        IMEM_BUSY = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h200;
        tick();
        chk("t5_br1_addr", IMEM_ADDRESS, 32'h10);
        chk("t5_br1_valid", 32'(IF_ID_VALID), 32'd0);
        BRANCH_TARGET = 32'h300;
        tick();
        BRANCH_TAKEN = 1'b0;
        chk("t5_br2_addr", IMEM_ADDRESS, 32'h10);
        tick();
        chk("t5_busy_addr", IMEM_ADDRESS, 32'h10);
        IMEM_BUSY = 1'b0; IMEM_READDATA = word(32'h10);
        tick();
        chk("t5_drop_valid", 32'(IF_ID_VALID), 32'd0);
        chk("t5_drop_instr", IF_ID_INSTRUCTION, NOP);
        chk("t5_new_addr", IMEM_ADDRESS, 32'h300);
        fetch("t5_f300", 32'h300);

        // PC wrap at the top of the address space
        redirect("wrap_br", 32'hFFFF_FFFC);
        fetch("wrap_f", 32'hFFFF_FFFC);
        chk("wrap_pc", PC, 32'h0);

        // 6: reset asserted mid-busy with PC=0x40
        redirect("t6_br", 32'h3C);
        fetch("t6_f3c", 32'h3C);
        IMEM_BUSY = 1'b1;
        tick();
        chk("t6_busy_addr", IMEM_ADDRESS, 32'h40);
        #2;
        RESET = 1'b0;
        #1;
        chk("t6_rst_pc", PC, 32'h0);
        chk("t6_rst_read", 32'(IMEM_READ), 32'd0);
        chk("t6_rst_valid", 32'(IF_ID_VALID), 32'd0);
        tick();
        RESET = 1'b1;
        fetch("t6_restart", 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
